// File: rtl/spectrum_pkg.sv
// Shared types and log-spacing tables for the spectrum bar engine.
// The tables cover the 256-point FFT / 16-bar layout only.
package spectrum_pkg;

    typedef enum logic {SPEC_LOG, SPEC_LIN} spec_mode_t;

    typedef enum logic [1:0] {IDLE, ACCUM, STORE} state_t;

    // Bar b covers bins [edge[b], edge[b+1]); recip is ceil(65536 / bin count).
    localparam int unsigned LOG_EDGES_256_16 [0:16] = '{
        0, 1, 2, 3, 4, 5, 7, 9, 12, 16, 24, 32, 44, 56, 72, 96, 128
    };

    localparam int unsigned LOG_RECIP_256_16 [0:15] = '{
        65536, 65536, 65536, 65536, 65536, 32768, 32768, 21846,
        16384, 8192, 8192, 5462, 5462, 4096, 2731, 2048
    };

endpackage

// File: rtl/spectrum_bar_peak.sv
// Peak marker for one bar: follows rising bars, holds for a number of
// vsync edges, then decays by one cell per edge.
module spectrum_bar_peak #(
    parameter int BW          = 5,
    parameter int HOLD_FRAMES = 8,
    localparam int HW         = $clog2(HOLD_FRAMES + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          update,
    input  logic          peak_en,
    input  logic [BW-1:0] bar,
    output logic [BW-1:0] peak
);

    logic [HW-1:0] hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak <= '0;
            hold <= '0;
        end else if (update) begin
            if (!peak_en) begin
                peak <= bar;
                hold <= '0;
            end else if (bar >= peak) begin
                peak <= bar;
                hold <= HW'(HOLD_FRAMES);
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end else begin
                peak <= ((peak - 1'b1) > bar) ? (peak - 1'b1) : bar;
            end
        end
    end

endmodule

// File: rtl/spectrum_bar_engine.sv
// Walks one FFT magnitude frame a bin per clock into BARS averaged, scaled
// and clamped bar heights, published to the display only on vsync rising edges.
module spectrum_bar_engine
    import spectrum_pkg::*;
#(
    parameter int         WIDTH       = 12,
    parameter int         N           = 256,
    parameter int         BARS        = 16,
    parameter spec_mode_t MODE        = SPEC_LOG,
    parameter int         SCALE_SHIFT = 7,
    parameter int         HEIGHT      = 30,
    parameter int         HOLD_FRAMES = 8,
    localparam int        BW          = $clog2(HEIGHT + 1)
) (
    input  logic               clk_50MHz,
    input  logic               rst,
    input  logic               fft_done,
    input  logic [WIDTH+1:0]   freq_samples [N],
    input  logic               vsync,
    input  logic               peak_en,
    output logic [BW-1:0]      bars [BARS],
    output logic [BW-1:0]      peaks [BARS],
    output logic               busy
);

    localparam int HALF   = N / 2;
    localparam int BIN_W  = $clog2(N);
    localparam int BAR_W  = (BARS > 1) ? $clog2(BARS) : 1;
    localparam int ACC_W  = WIDTH + 2 + $clog2(HALF);
    localparam int PROD_W = ACC_W + 17;
    localparam int K      = HALF / BARS;
    localparam int LOG2K  = $clog2(K);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [BIN_W-1:0] bin;
    logic [BAR_W-1:0] b;
    logic             pending;
    logic             frame_ready;
    logic [BW-1:0]    work [BARS];

    logic             vs_meta, vs_sync, vs_prev, vs_rise;

    logic [BIN_W-1:0] last_tab  [BARS];
    logic [16:0]      recip_tab [BARS];

    for (genvar g = 0; g < BARS; g++) begin : g_tab
        if (MODE == SPEC_LOG) begin : g_log
            assign last_tab[g]  = BIN_W'(LOG_EDGES_256_16[g+1] - 1);
            assign recip_tab[g] = 17'(LOG_RECIP_256_16[g]);
        end else begin : g_lin
            assign last_tab[g]  = BIN_W'((g + 1) * K - 1);
            assign recip_tab[g] = '0;
        end
    end

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  avg;
    logic [ACC_W-1:0]  scaled;
    logic [BW-1:0]     store_val;

    always_comb begin
        prod = PROD_W'(acc) * PROD_W'(recip_tab[b]);
        if (MODE == SPEC_LOG)
            avg = ACC_W'(prod >> 16);
        else
            avg = acc >> LOG2K;
        scaled    = avg >> SCALE_SHIFT;
        store_val = (scaled > ACC_W'(HEIGHT)) ? BW'(HEIGHT) : BW'(scaled);
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign vs_rise = vs_sync & ~vs_prev;

    // frame_ready drops when ACCUM starts, so a half-rewritten work[] is never copied.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            bin         <= '0;
            b           <= '0;
            pending     <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < BARS; i++) work[i] <= '0;
        end else begin
            if (fft_done && state != IDLE) pending <= 1'b1;
            if (vs_rise && frame_ready) frame_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (fft_done || pending) begin
                        state       <= ACCUM;
                        busy        <= 1'b1;
                        acc         <= '0;
                        bin         <= '0;
                        b           <= '0;
                        frame_ready <= 1'b0;
                        pending     <= 1'b0;
                    end
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(freq_samples[bin]);
                    bin <= bin + 1'b1;
                    if (bin == last_tab[b]) state <= STORE;
                end
                STORE: begin
                    work[b] <= store_val;
                    acc     <= '0;
                    if (b == BAR_W'(BARS - 1)) begin
                        frame_ready <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        b     <= b + 1'b1;
                        state <= ACCUM;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BARS; i++) bars[i] <= '0;
        end else if (vs_rise && frame_ready) begin
            for (int i = 0; i < BARS; i++) bars[i] <= work[i];
        end
    end

    // Peaks see the bar value that is being published on this same edge.
    for (genvar g = 0; g < BARS; g++) begin : g_peak
        logic [BW-1:0] bar_next;
        assign bar_next = (vs_rise && frame_ready) ? work[g] : bars[g];

        spectrum_bar_peak #(
            .BW          (BW),
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_peak (
            .clk     (clk_50MHz),
            .rst     (rst),
            .update  (vs_rise),
            .peak_en (peak_en),
            .bar     (bar_next),
            .peak    (peaks[g])
        );
    end

endmodule

// File: tb/tb_spectrum_bar_engine.sv
// Directed bench for spectrum_bar_engine: known magnitude frames, vsync
// pulses, peak hold/decay, frame queueing and mid-frame reset.
module tb_spectrum_bar_engine;

    logic        clk_50MHz;
    logic        rst;
    logic        fft_done;
    logic [13:0] freq_samples [256];
    logic        vsync;
    logic        peak_en;
    logic [4:0]  bars  [16];
    logic [4:0]  peaks [16];
    logic        busy;

    int checks = 0;
    int errors = 0;

    spectrum_bar_engine #(
        .HOLD_FRAMES (4)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .rst          (rst),
        .fft_done     (fft_done),
        .freq_samples (freq_samples),
        .vsync        (vsync),
        .peak_en      (peak_en),
        .bars         (bars),
        .peaks        (peaks),
        .busy         (busy)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [13:0] fill, input int spike_bin, input logic [13:0] spike_val);
        for (int i = 0; i < 256; i++) freq_samples[i] = fill;
        if (spike_bin >= 0) freq_samples[spike_bin] = spike_val;
    endtask

    task automatic pulseDone();
        @(posedge clk_50MHz); #1 fft_done = 1'b1;
        @(posedge clk_50MHz); #1 fft_done = 1'b0;
    endtask

    task automatic runFrame(output int busy_cycles);
        pulseDone();
        busy_cycles = 0;
        while (busy && busy_cycles < 1000) begin
            @(posedge clk_50MHz); #1;
            busy_cycles++;
        end
    endtask

    task automatic vsyncPulse();
        @(posedge clk_50MHz); #1 vsync = 1'b1;
        repeat (4) @(posedge clk_50MHz);
        #1 vsync = 1'b0;
        repeat (4) @(posedge clk_50MHz);
        #1;
    endtask

    task automatic checkAllBars(input string tag, input logic [4:0] expected);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("%s bar%0d", tag, i), 32'(bars[i]), 32'(expected));
    endtask

    initial begin
        int n;
        int gap;
        rst      = 1'b1;
        fft_done = 1'b0;
        vsync    = 1'b0;
        peak_en  = 1'b1;
        applyStimulus(14'd0, -1, 14'd0);
        repeat (3) @(posedge clk_50MHz);
        #1;
        checkOutput("reset bars0", 32'(bars[0]), 32'd0);
        checkOutput("reset peaks0", 32'(peaks[0]), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Flat 1280: every bar averages 1280, >>7 gives 10.
        applyStimulus(14'd1280, -1, 14'd0);
        runFrame(n);
        checkOutput("flat busy cycles", 32'(n), 32'd144);
        checkOutput("flat unpublished", 32'(bars[0]), 32'd0);
        vsyncPulse();
        checkAllBars("flat1280", 5'd10);
        checkOutput("flat peak3", 32'(peaks[3]), 32'd10);

        applyStimulus(14'd16383, -1, 14'd0);
        runFrame(n);
        vsyncPulse();
        checkAllBars("clamp", 5'd30);

        // Single bin 100 lands in bar 15 (32 bins): 8192/32 = 256, >>7 = 2.
        applyStimulus(14'd0, 100, 14'd8192);
        runFrame(n);
        vsyncPulse();
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("spike bar%0d", i), 32'(bars[i]), (i == 15) ? 32'd2 : 32'd0);

        peak_en = 1'b0;
        vsyncPulse();
        checkOutput("track peak15", 32'(peaks[15]), 32'd2);
        checkOutput("track peak0", 32'(peaks[0]), 32'd0);

        // Bar 0 to 20, then to 0: hold 4 edges, then decay one per edge.
        peak_en = 1'b1;
        applyStimulus(14'd0, 0, 14'd2560);
        runFrame(n);
        vsyncPulse();
        checkOutput("peak bar0", 32'(bars[0]), 32'd20);
        checkOutput("peak set", 32'(peaks[0]), 32'd20);
        applyStimulus(14'd0, -1, 14'd0);
        runFrame(n);
        for (int e = 1; e <= 8; e++) begin
            vsyncPulse();
            checkOutput($sformatf("decay edge%0d", e), 32'(peaks[0]), (e <= 4) ? 32'd20 : 32'(24 - e));
        end
        checkOutput("decay bar0", 32'(bars[0]), 32'd0);
        peak_en = 1'b0;
        vsyncPulse();
        checkOutput("peak off", 32'(peaks[0]), 32'd0);

        // Queueing: done pulses at cycles 50 and 60 of a frame give one extra frame.
        applyStimulus(14'd640, -1, 14'd0);
        pulseDone();
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk_50MHz); #1;
            n++;
            fft_done = (n == 50 || n == 60);
        end
        fft_done = 1'b0;
        checkOutput("queue frameA cycles", 32'(n), 32'd144);
        gap = 0;
        while (!busy && gap < 50) begin
            @(posedge clk_50MHz); #1;
            gap++;
        end
        checkOutput("queue restart gap", 32'(gap), 32'd1);
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk_50MHz); #1;
            n++;
            vsync = (n >= 20 && n < 26);
        end
        vsync = 1'b0;
        checkOutput("queue frameB cycles", 32'(n), 32'd144);
        checkOutput("no tear", 32'(bars[0]), 32'd0);
        n = 0;
        repeat (200) begin
            @(posedge clk_50MHz); #1;
            if (busy) n++;
        end
        checkOutput("third dropped", 32'(n), 32'd0);
        vsyncPulse();
        checkOutput("queue bar0", 32'(bars[0]), 32'd5);
        checkOutput("queue bar15", 32'(bars[15]), 32'd5);
        checkOutput("queue peak0", 32'(peaks[0]), 32'd5);

        // Reset 70 cycles into ACCUM clears outputs asynchronously.
        applyStimulus(14'd1280, -1, 14'd0);
        pulseDone();
        repeat (70) @(posedge clk_50MHz);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst bars0", 32'(bars[0]), 32'd0);
        checkOutput("rst bars15", 32'(bars[15]), 32'd0);
        checkOutput("rst peaks0", 32'(peaks[0]), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        @(posedge clk_50MHz); #1 rst = 1'b0;
        runFrame(n);
        checkOutput("post-rst busy cycles", 32'(n), 32'd144);
        vsyncPulse();
        checkAllBars("post-rst", 5'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spectrum_bar_engine.md
# spectrum_bar_engine

Parametrised successor to the fixed 16-bar histogram logic: converts one FFT magnitude frame into `BARS` display bar heights. Bins are walked one per clock instead of summed in one giant adder tree. Bars are averaged in either log-spaced or linear groups, scaled, and clamped to the screen height. Results are published on the vsync rising edge only, with optional peak-hold/decay markers. It sits between the FFT core and the VGA pixel colour logic, on the `clk_50MHz` domain.

## Interface
- `WIDTH`, 12: FFT sample width; magnitudes are `WIDTH+2` bits.
- `N`, 256: FFT size; only bins 0..N/2-1 are used.
- `BARS`, 16: number of output bars.
- `MODE`, `SPEC_LOG`: `SPEC_LOG` uses the package edge table (requires N=256, BARS=16). `SPEC_LIN` uses K=(N/2)/BARS bins per bar, where K is a power of two.
- `SCALE_SHIFT`, 7: right shift applied to the bar average.
- `HEIGHT`, 30: clamp ceiling, in bar cells.
- `HOLD_FRAMES`, 8: number of vsync edges a peak holds before it decays.
- `clk_50MHz`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `fft_done`  in  1  one-cycle pulse: a new frame is valid on `freq_samples`.
- `freq_samples`  in  [WIDTH+1:0] x N  bin magnitudes; held stable by the FFT until its next `fft_done`.
- `vsync`  in  1  from the VGA domain (25 MHz); treated as asynchronous.
- `peak_en`  in  1  enables peak tracking.
- `bars`  out  [BW-1:0] x BARS  displayed heights, where BW=$clog2(HEIGHT+1).
- `peaks`  out  [BW-1:0] x BARS  peak markers.
- `busy`  out  1  high while the accumulate FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCUM, STORE.
  - IDLE → ACCUM on `fft_done`, or on the `pending` flag. Clears `acc`, `bin`=0, `b`=0, `frame_ready`=0.
  - ACCUM: each cycle, `acc += freq_samples[bin]` and `bin++`. On the last bin of bar `b` (bin = edge[b+1]-1), go to STORE.
  - STORE: write `work[b]` = min(avg >> SCALE_SHIFT, HEIGHT), then clear `acc` and increment `b`. If `b`=BARS-1, set `frame_ready` and go to IDLE; otherwise go back to ACCUM.
- Log mode edges: 0,1,2,3,4,5,7,9,12,16,24,32,44,56,72,96,128.
- Averaging:
  - Log mode: avg = (acc × RECIP[b]) >> 16, with RECIP[b] = ceil(65536/count).
  - Linear mode: avg = acc >> log2(K).
- Widths: `acc` is WIDTH+2+$clog2(N/2) bits; the product is acc width + 17 bits. Arithmetic is unsigned and truncates.
- A `fft_done` arriving while busy sets `pending`; only one frame is queued. Further pulses while pending are dropped.
- `vsync` passes through a 2-FF synchroniser plus an edge register. On a rising edge with `frame_ready`=1: `bars` ← `work`, `frame_ready` ← 0. A new frame never tears, because `frame_ready` is cleared when ACCUM starts.
- Peak update, per bar, on every vsync rising edge (after the bars copy, using the new bar value):
  - If the new bar ≥ peak: peak ← bar, hold ← HOLD_FRAMES.
  - Else if hold > 0: hold decrements.
  - Else: peak ← max(peak-1, bar).
  - If `peak_en`=0: peak ← bar and hold ← 0.
- Reset sets every register to 0: `bars`, `peaks`, `work`, `hold`, `acc`, `pending`, `frame_ready`, `busy`. State returns to IDLE. Reset mid-ACCUM discards the partial frame.

## Timing
- Log mode: `fft_done` at cycle 0 → `frame_ready` set at cycle 128+16 = 144.
- Linear mode: N/2+BARS cycles.
- `bars`/`peaks` change 3 cycles after the vsync rising edge reaches the pin, and never at any other time.
- `frame_ready` set in the same cycle as a synchronised vsync edge: the copy is deferred to the next edge.
- Pending restart: ACCUM re-enters the cycle after the final STORE.
- `busy` is registered and goes high the cycle after `fft_done`.

## Structure
- Package `spectrum_pkg` holds:
  - the `spec_mode_t` enum (`SPEC_LOG`, `SPEC_LIN`);
  - the FSM state enum;
  - the `LOG_EDGES_256_16[0:16]` and `LOG_RECIP_256_16[0:15]` constants.
- One sub-module, `spectrum_bar_peak` (a single bar's peak/hold register pair), is instantiated BARS times in a generate loop.

## Test plan
- WIDTH=12, all bins 1280, `fft_done` → at the next vsync edge all 16 bars = 10; `busy` is high for exactly 144 cycles.
- All bins 16383 → every bar clamps to 30.
- Bin 100 = 8192, all others 0 → bar 15 = 2 (256 >> 7); all other bars = 0.
- Bar 0 driven to 20, then to 0, with `peak_en`=1 and HOLD_FRAMES=4 → `peaks[0]` stays 20 for 4 edges, then reads 19, 18, …, 0. With `peak_en`=0, `peaks` tracks `bars`.
- Second `fft_done` at cycle 50 of a frame, third at cycle 60 → exactly two frames are computed back-to-back; the third is dropped. No vsync edge ever shows a partial frame.
- `rst` asserted at cycle 70 of ACCUM → all outputs are 0 immediately. After release, the next `fft_done` yields correct bars.
